// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the multicycle MIPS controller:
//     - state_t      : FSM state encodings (codes 12..15 are unused)
//     - OP_*         : primary opcode values (instruction bits [31:26])
//     - ALUOP_*      : ALU operation selector handed to the ALU control
//     - SRCB_*/PCSRC_*: mux select encodings for ALUSrcB and PCSource
//     - ctrl_t       : bundle of every datapath control produced per state
//     - opcode_known : true for the opcodes this controller implements
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand: register B, constant 4, sign-extended immediate,
    // sign-extended immediate shifted left by two (branch offset).
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    // PC source: ALU result (PC+4), ALUOut (branch target), jump target.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic opcode_known(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// ---------------------------------------------------------------------------
// mc_out_decode
//   Purely combinational map from controller state to datapath controls.
//   Every control defaults to 0, so any state (including unused codes)
//   only drives what it explicitly lists.
//
//   Ports
//     state     in  [3:0]  current FSM state code
//     mem_ready in  1      memory access completes this cycle; only used to
//                          qualify the FETCH-cycle IRWrite/PCWrite
//     ctrl      out ctrl_t all datapath controls for this cycle
// ---------------------------------------------------------------------------
module mc_out_decode
    import mips_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // Latch the instruction and bump the PC only on the cycle the
                // read actually returns; while waiting the PC must not move.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_BOFF;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADDR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_dst    = 1'b0;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                // The datapath ANDs PCWriteCond with the ALU zero flag.
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: begin
                // Unused codes: everything stays at 0.
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Control unit for a classic multicycle MIPS datapath (R-type, lw, sw,
//   beq, j, addi). Holds the FSM state register, the next-state logic and a
//   counter of retired instructions; output decoding is in mc_out_decode.
//
//   Parameters
//     CNT_W       width of the retired-instruction counter
//
//   Ports
//     clk         in   single clock, rising edge
//     rst_n       in   asynchronous active-low reset
//     opcode      in   [5:0] instruction bits [31:26] from the IR
//     zero        in   ALU zero flag (consumed by the datapath, not here)
//     mem_ready   in   memory completes the current access this cycle
//     PCWrite .. ALUSrcA   out  1-bit datapath controls
//     ALUSrcB, PCSource, ALUop  out [1:0] mux selects / ALU operation
//     state       out  [3:0] current FSM state code
//     illegal     out  high during the DECODE cycle of an unknown opcode
//     retired     out  [CNT_W-1:0] count of completed instructions (wraps)
// ---------------------------------------------------------------------------
module multicycle_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUop,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    // Kept as a raw 4-bit code rather than state_t so the unused codes
    // 12..15 are representable and recoverable.
    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             illegal_op;
    ctrl_t            ctrl;

    // The zero flag gates the branch in the datapath; it is only part of
    // this port list so the controller and datapath share one interface.
    logic unused_zero;
    assign unused_zero = zero;

    // -----------------------------------------------------------------------
    // State and counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. opcode is looked at only in DECODE and MEMADDR; the
    // IR is not rewritten until the next FETCH, so those are the only states
    // that need it.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = S_FETCH;
        retire     = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: begin
                // Only lw/sw reach here; anything else means the IR changed
                // underneath us, so drop the instruction without counting it.
                if (opcode == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD: begin
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: begin
                // Unused code: recover to FETCH, no retirement.
                state_d = S_FETCH;
            end
        endcase
    end

    // Counter wraps naturally at 2^CNT_W.
    always_comb begin
        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    mc_out_decode u_out_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // While reset is held the state already decodes as FETCH, but a ready
    // memory would still raise PCWrite/IRWrite; the write enables are masked
    // directly with rst_n so nothing is committed during reset.
    assign PCWrite     = ctrl.pc_write  & rst_n;
    assign IRWrite     = ctrl.ir_write  & rst_n;
    assign RegWrite    = ctrl.reg_write & rst_n;
    assign MemWrite    = ctrl.mem_write & rst_n;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign ALUop       = ctrl.alu_op;

    assign state   = state_q;
    assign illegal = illegal_op & rst_n;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Directed bench for multicycle_control (CNT_W=4 so the counter wrap is
//   reachable). A table of instructions gives the expected state sequence;
//   a table indexed by state gives the expected control word. Hand-written
//   sequences cover memory wait states, reset mid-instruction and the wrap.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0]       ALUSrcB, PCSource, ALUop;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .ALUop       (ALUop),
        .state       (state),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [5:0]     op;
        int             len;
        logic [0:4][3:0] seq;
        bit             ret;
        bit             ill;
    } vec_t;

    vec_t        vecs [7];
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,
    //  RegDst,ALUSrcA, ALUSrcB[1:0], PCSource[1:0], ALUop[1:0]}
    // FETCH entry assumes mem_ready=1.
    logic [15:0] ctrl_exp [12];

    int               n_pass = 0;
    int               n_chk  = 0;
    logic [CNT_W-1:0] exp_ret;

    function automatic logic [15:0] ctrl_now();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUop};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Runs one table instruction from FETCH. Opcode is presented only in
    // DECODE/MEMADDR; junk elsewhere must be ignored.
    task automatic run_vec(input int i);
        logic [3:0] s;
        for (int k = 0; k < vecs[i].len; k++) begin
            s         = vecs[i].seq[k];
            mem_ready = 1'b1;
            opcode    = (s == 4'd1 || s == 4'd2) ? vecs[i].op : 6'h3F;
            #1;
            chk($sformatf("%s state c%0d", vecs[i].name, k), 32'(state), 32'(s));
            chk($sformatf("%s ctrl s%0d", vecs[i].name, s), 32'(ctrl_now()), 32'(ctrl_exp[s]));
            chk($sformatf("%s illegal c%0d", vecs[i].name, k), 32'(illegal),
                32'(s == 4'd1 && vecs[i].ill));
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        if (vecs[i].ret) exp_ret = exp_ret + 1'b1;
        chk($sformatf("%s end state", vecs[i].name), 32'(state), 32'd0);
        chk($sformatf("%s retired", vecs[i].name), 32'(retired), 32'(exp_ret));
        $display("instr %-7s op=0x%02h cycles=%0d retired=%0d", vecs[i].name, vecs[i].op,
                 vecs[i].len, retired);
    endtask

    initial begin
        vecs[0] = '{"R-type",  6'h00, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 1'b1, 1'b0};
        vecs[1] = '{"lw",      6'h23, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 1'b1, 1'b0};
        vecs[2] = '{"sw",      6'h2B, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}, 1'b1, 1'b0};
        vecs[3] = '{"beq",     6'h04, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0}, 1'b1, 1'b0};
        vecs[4] = '{"j",       6'h02, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 1'b1, 1'b0};
        vecs[5] = '{"addi",    6'h08, 4, {4'd0, 4'd1, 4'd10, 4'd11, 4'd0}, 1'b1, 1'b0};
        vecs[6] = '{"illegal", 6'h3F, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0}, 1'b0, 1'b1};

        ctrl_exp[0]  = {10'b1001010000, 2'b01, 2'b00, 2'b00}; // FETCH (ready)
        ctrl_exp[1]  = {10'b0000000000, 2'b11, 2'b00, 2'b00}; // DECODE
        ctrl_exp[2]  = {10'b0000000001, 2'b10, 2'b00, 2'b00}; // MEMADDR
        ctrl_exp[3]  = {10'b0011000000, 2'b00, 2'b00, 2'b00}; // MEMREAD
        ctrl_exp[4]  = {10'b0000001100, 2'b00, 2'b00, 2'b00}; // MEMWB
        ctrl_exp[5]  = {10'b0010100000, 2'b00, 2'b00, 2'b00}; // MEMWRITE
        ctrl_exp[6]  = {10'b0000000001, 2'b00, 2'b00, 2'b10}; // EXEC
        ctrl_exp[7]  = {10'b0000000110, 2'b00, 2'b00, 2'b00}; // RWB
        ctrl_exp[8]  = {10'b0100000001, 2'b00, 2'b01, 2'b01}; // BRANCH
        ctrl_exp[9]  = {10'b1000000000, 2'b00, 2'b10, 2'b00}; // JUMP
        ctrl_exp[10] = {10'b0000000001, 2'b10, 2'b00, 2'b00}; // ADDIEX
        ctrl_exp[11] = {10'b0000000100, 2'b00, 2'b00, 2'b00}; // ADDIWB

        // ---- reset state: write enables masked even with memory ready ----
        rst_n     = 1'b0;
        opcode    = 6'h00;
        zero      = 1'b1;
        mem_ready = 1'b1;
        exp_ret   = '0;
        @(negedge clk);
        #1;
        chk("reset state", 32'(state), 32'd0);
        chk("reset retired", 32'(retired), 32'd0);
        chk("reset illegal", 32'(illegal), 32'd0);
        chk("reset PCWrite", 32'(PCWrite), 32'd0);
        chk("reset IRWrite", 32'(IRWrite), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table-driven instructions ----
        for (int i = 0; i < 7; i++) run_vec(i);

        // ---- FETCH holds while memory is not ready, no IR/PC write ----
        for (int k = 0; k < 2; k++) begin
            mem_ready = 1'b0;
            #1;
            chk($sformatf("fetch wait state c%0d", k), 32'(state), 32'd0);
            chk($sformatf("fetch wait ctrl c%0d", k), 32'(ctrl_now()),
                32'({10'b0001000000, 2'b01, 2'b00, 2'b00}));
            @(posedge clk);
            @(negedge clk);
        end
        $display("instr fetch-wait 2 cycles");
        run_vec(4);

        // ---- sw with three MEMWRITE wait cycles ----
        opcode = 6'h2B;
        for (int k = 0; k < 7; k++) begin
            mem_ready = (k < 3 || k == 6) ? 1'b1 : 1'b0;
            #1;
            if (k >= 3) begin
                chk($sformatf("sw wait state c%0d", k), 32'(state), 32'd5);
                chk($sformatf("sw wait MemWrite c%0d", k), 32'(MemWrite), 32'd1);
            end
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        exp_ret = exp_ret + 1'b1;
        chk("sw wait end state", 32'(state), 32'd0);
        chk("sw wait retired", 32'(retired), 32'(exp_ret));
        $display("instr sw-wait  op=0x2b cycles=7 retired=%0d", retired);

        // ---- reset asserted while lw waits in MEMREAD ----
        opcode = 6'h23;
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k < 3) ? 1'b1 : 1'b0;
            if (k < 3) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        #1;
        chk("rst mid MEMREAD pre", 32'(state), 32'd3);
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        exp_ret = '0;
        chk("rst mid state", 32'(state), 32'd0);
        chk("rst mid retired", 32'(retired), 32'd0);
        chk("rst mid writes", 32'({MemWrite, RegWrite, PCWrite, IRWrite}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst held state", 32'(state), 32'd0);
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("post rst state", 32'(state), 32'd0);
        chk("post rst retired", 32'(retired), 32'd0);
        $display("instr lw-reset abandoned in MEMREAD retired=%0d", retired);

        // ---- 16 jumps wrap the 4-bit counter back to 0 ----
        for (int n = 0; n < 16; n++) run_vec(4);
        chk("wrap retired zero", 32'(retired), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, the width of the retired-instruction counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-005 The block SHALL have port zero, input, 1, the ALU zero flag.
REQ-006 The block SHALL have port mem_ready, input, 1, memory completes the current access this cycle.
REQ-007 The block SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA, each 1 bit, the standard multicycle datapath controls.
REQ-008 The block SHALL have outputs ALUSrcB (2), PCSource (2) and ALUop (2); ALUop uses the existing encoding: 00 add, 01 subtract, 10 decode funct.
REQ-009 The block SHALL have outputs state (4), illegal (1, one-cycle pulse) and retired (CNT_W bits).

Function
REQ-010 The FSM SHALL have states FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 are unused.
REQ-011 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00; it holds while mem_ready=0. IRWrite and PCWrite SHALL be asserted only in the cycle where mem_ready=1, and the FSM then goes to DECODE.
REQ-012 DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00. Next state by opcode: 0x00 to EXEC, 0x23 or 0x2B to MEMADDR, 0x04 to BRANCH, 0x02 to JUMP, 0x08 to ADDIEX; any other opcode to FETCH with illegal=1 for that cycle.
REQ-013 MEMADDR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUop=00. MEMADDR goes to MEMREAD for 0x23 and to MEMWRITE for 0x2B. ADDIEX goes to ADDIWB.
REQ-014 MEMREAD: MemRead=1, IorD=1; it holds until mem_ready=1, then goes to MEMWB.
REQ-015 MEMWRITE: MemWrite=1, IorD=1; it holds until mem_ready=1, then goes to FETCH.
REQ-016 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. ADDIWB: RegWrite=1, MemtoReg=0, RegDst=0. Both go to FETCH.
REQ-017 EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10, then RWB. RWB: RegWrite=1, RegDst=1, MemtoReg=0, then FETCH.
REQ-018 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01, then FETCH; the datapath gates the PC update with zero.
REQ-019 JUMP: PCWrite=1, PCSource=10, then FETCH.
REQ-020 Any output not listed for a state SHALL be 0 in that state.
REQ-021 All outputs except the FETCH-cycle IRWrite/PCWrite SHALL be Moore, decoded from state only.
REQ-022 The opcode SHALL be sampled only in DECODE and MEMADDR; opcode changes in other states have no effect.
REQ-023 retired SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWRITE, RWB, BRANCH, JUMP or ADDIWB, and wrap from 2^CNT_W-1 to 0. Illegal-opcode returns SHALL NOT increment it.
REQ-024 An unused state code SHALL force a transition to FETCH on the next edge, with no writes asserted.
REQ-025 Cycle counts with zero memory wait SHALL be: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.

Reset
REQ-026 When rst_n=0, the FSM SHALL asynchronously enter FETCH, with retired=0 and illegal=0.
REQ-027 During reset all write enables (PCWrite, IRWrite, RegWrite, MemWrite) SHALL be 0, overriding FETCH decode.
REQ-028 Reset asserted mid-instruction SHALL abandon that instruction; it is not counted in retired.
REQ-029 The first FETCH after rst_n deassertion SHALL begin on the next rising edge.

Structure
REQ-030 The state encodings, opcode constants (0x00, 0x23, 0x2B, 0x04, 0x02, 0x08) and ALUop encodings SHALL live in the shared package mips_pkg.
REQ-031 One sub-module, mc_out_decode, SHALL be combinational and map state to the control outputs; the next-state logic and counter stay in the top.

Verification
REQ-032 lw (0x23) with mem_ready=1: the state sequence SHALL be 0,1,2,3,4,0, RegWrite=1 only in state 4, and retired SHALL go 0 to 1.
REQ-033 sw with mem_ready low for 3 cycles in MEMWRITE: the FSM SHALL stay in state 5 for 4 cycles, with MemWrite=1 throughout, then go to FETCH.
REQ-034 Opcode 0x3F: DECODE SHALL pulse illegal=1, return to FETCH, and leave retired unchanged.
REQ-035 beq with zero=1 and R-type: beq SHALL give PCWriteCond=1 and PCSource=01 in state 8; R-type SHALL give ALUop=10 in state 6.
REQ-036 With CNT_W=4, 16 j instructions SHALL wrap retired to 0.
REQ-037 rst_n pulsed low in MEMREAD SHALL give an immediate state of 0, retired=0, and no MemWrite or RegWrite.
